// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR pseudo-random source with on-line period measurement.
//
// Streams the LFSR state over a valid/ready interface. The feedback form
// (Galois or Fibonacci) is selected at run time. A seed can be loaded, and an
// all-zero load is replaced by SEED. Every time the sequence returns to the
// state where measurement started, the period is reported.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   mode         in   0 = Galois, 1 = Fibonacci, sampled every cycle
//   load         in   load load_val into the state this cycle (wins over advance)
//   load_val     in   value to load; zero is replaced by SEED
//   out_ready    in   consumer accepts out_data
//   out_valid    out  out_data valid; high from the first cycle after reset
//   out_data     out  current LFSR state (the state register itself)
//   lockup       out  one-cycle pulse: a zero state was replaced by SEED
//   period_valid out  one-cycle pulse: period was just updated
//   period       out  last measured sequence length (saturates at all-ones)
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup,
    output logic             period_valid,
    output logic [WIDTH-1:0] period
);

    localparam int unsigned W = WIDTH;

    // Elaboration-time sanity checks on the parameters.
    if (W < 2) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be at least 2");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    // State, measurement registers and registered mode.
    logic [W-1:0] s;
    logic [W-1:0] ref_state;
    logic [W-1:0] cnt;
    logic         mode_q;

    // Next-state and measurement helpers.
    logic [W-1:0] galois_next;
    logic [W-1:0] fib_next;
    logic [W-1:0] step_raw;
    logic         step_zero;
    logic [W-1:0] step_next;
    logic         advance;
    logic         mode_change;
    logic [W-1:0] meas_ref;
    logic [W-1:0] meas_cnt;
    logic [W-1:0] cnt_inc;
    logic         wrap;
    logic         load_zero;

    assign out_data = s;

    // One LFSR step in both forms; the current mode input picks the form.
    always_comb begin
        galois_next = {s[W-2:0], 1'b0} ^ (s[W-1] ? TAPS : '0);
        fib_next    = {s[W-2:0], ^(s & TAPS)};
        step_raw    = mode ? fib_next : galois_next;
        // A degenerate tap mask can fall into zero; recover to SEED like a zero load.
        step_zero   = (step_raw == '0);
        step_next   = step_zero ? SEED : step_raw;
    end

    // Transfer and measurement bookkeeping.
    always_comb begin
        advance     = out_valid && out_ready && !load;
        mode_change = (mode != mode_q);
        load_zero   = (load_val == '0);
        // On a mode change the measurement restarts from the present state and
        // an advance in the same cycle becomes its first step.
        meas_ref    = mode_change ? s  : ref_state;
        meas_cnt    = mode_change ? '0 : cnt;
        cnt_inc     = (meas_cnt == '1) ? '1 : meas_cnt + W'(1);
        wrap        = (step_next == meas_ref);
    end

    // State register, measurement and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            s            <= SEED;
            ref_state    <= SEED;
            cnt          <= '0;
            mode_q       <= mode;
            out_valid    <= 1'b0;
            lockup       <= 1'b0;
            period_valid <= 1'b0;
            period       <= '0;
        end else begin
            out_valid    <= 1'b1;
            mode_q       <= mode;
            lockup       <= 1'b0;
            period_valid <= 1'b0;
            if (load) begin
                // Load wins over advance and mode change; measurement restarts here.
                if (load_zero) begin
                    s         <= SEED;
                    ref_state <= SEED;
                    lockup    <= 1'b1;
                end else begin
                    s         <= load_val;
                    ref_state <= load_val;
                end
                cnt <= '0;
            end else if (advance) begin
                s         <= step_next;
                lockup    <= step_zero;
                ref_state <= meas_ref;
                if (wrap) begin
                    period       <= cnt_inc;
                    period_valid <= 1'b1;
                    cnt          <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end else if (mode_change) begin
                ref_state <= s;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised LFSR pseudo-random source: the next-generation LFSR block for the exercise set. It supports configurable width and tap mask, run-time Galois/Fibonacci mode select, seed load, and zero lock-up recovery. It streams states over a valid/ready interface and measures the sequence period on-line, so it can serve as a stimulus source or as a self-checking polynomial explorer.

## Interface
- WIDTH, 8, state width in bits (≥2)
- TAPS, 8'h1D, feedback mask [WIDTH-1:0]; default 8'h1D is the maximal polynomial x^8+x^4+x^3+x^2+1
- SEED, 1, reset and recovery state (must be nonzero)

Clock and reset are decided: one clock; reset is synchronous and active-high.

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- mode  in  1  0 = Galois, 1 = Fibonacci; sampled every cycle
- load  in  1  load load_val into state this cycle
- load_val  in  WIDTH  value to load
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  out_data valid
- out_data  out  WIDTH  current LFSR state
- lockup  out  1  one-cycle pulse: zero load replaced by SEED
- period_valid  out  1  one-cycle pulse: period updated
- period  out  WIDTH  last measured sequence length

## Operation
- State register s. out_data = s directly, with no extra register.
- Advance happens on out_valid && out_ready && !load.
- Galois: s_next = {s[W-2:0],1'b0} ^ (s[W-1] ? TAPS : 0).
- Fibonacci: s_next = {s[W-2:0], ^(s & TAPS)}.
- Load has priority over advance:
  - Nonzero load_val: s ← load_val.
  - Zero load_val: s ← SEED and lockup pulses the next cycle.
  - Load while out_ready is high does not count as a transfer; the old value is not advanced.
- Period measurement:
  - Registers ref (measurement start state) and cnt (WIDTH bits, saturating at all-ones).
  - On each advance: if s_next == ref, then period ← cnt+1, period_valid pulses, cnt ← 0. Otherwise cnt ← cnt+1.
  - Measurement restarts (ref ← new or current state, cnt ← 0) on reset, on any load, and on a mode change.
  - Mode change is detected against registered mode_q. The advance in that cycle uses the new mode. It counts as step 1 of the new measurement, with ref = s before the step.
  - With a saturated cnt, wrap still reports period = all-ones.
- Output after reset, before any completed period:
  - period = 0.
  - period_valid is never asserted.

## Timing
- Reset values: s = SEED, out_valid = 0, lockup = 0, period_valid = 0, period = 0, cnt = 0, ref = SEED, mode_q = mode.
- out_valid rises the first cycle after rst deasserts and stays high until the next reset. Loads do not drop it.
- Latency:
  - Handshake at edge n gives new out_data after edge n.
  - Load at edge n gives loaded value after edge n.
  - lockup and period_valid are registered and high exactly the cycle after the causing edge.
- out_ready low: s, cnt, ref hold. No bubbles.
- rst mid-stream overrides load and handshake; the next cycle matches the reset values.
- Simultaneous load and mode change: load wins; the measurement restarts from the loaded state.

## Test plan
- WIDTH=4, TAPS=4'h3, Galois, out_ready=1 after reset. Required sequence: 0001,0010,0100,1000,0011,0110,1100,1011,0101,1010,0111,1110,1111,1101,1001,0001. period_valid pulses with period=15 on the wrap.
- WIDTH=4, TAPS=4'b0101, Galois. Required sequence: 0001,0010,0100,1000,0101,1010,0001. period=6 on every wrap.
- WIDTH=4, TAPS=4'b1001, mode=1 from reset. Required sequence: 0001,0011,0111,1111,1110,1101,1010,0101,1011,0110,1100,1001,0010,0100,1000,0001. period=15.
- Toggle out_ready randomly for 40 cycles (TAPS=4'h3). Accepted values must equal the directed sequence with no skips or repeats, and out_data must be stable while out_ready is low.
- Edge cases:
  - load=1, load_val=0: s=0001 and lockup=1 for one cycle.
  - Load 4'b1011 with out_ready=1: out_data=1011 next cycle, not advanced, and the next period report is 15.
- Reset mid-sequence (state 1100) with simultaneous load: s=SEED, period=0, out_valid=0 for one cycle. Then the sequence resumes from 0001.
